// File: rtl/gen_tap_bank.sv
// Multi-channel tap-line bank: channel c keeps the last c+1 accepted samples and reports
// the oldest tap, the window sum or the window XOR (MODE). Optional sync flush: GEN_TAP_BANK_FLUSH_EN.
module gen_tap_bank #(
    parameter  int WIDTH = 8,
    parameter  int NCH   = 4,
    parameter  int MODE  = 0,
    localparam int SUMW  = $clog2(NCH + 1),
    localparam int OW    = WIDTH + SUMW
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef GEN_TAP_BANK_FLUSH_EN
    input  logic                 flush,
`endif
    input  logic                 in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic [NCH-1:0]       out_valid,
    output logic [NCH*OW-1:0]    out_data
);

    logic clear;
`ifdef GEN_TAP_BANK_FLUSH_EN
    assign clear = flush;
`else
    assign clear = 1'b0;
`endif

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        localparam int              DEPTH = c + 1;
        localparam logic [SUMW-1:0] FULL  = SUMW'(c + 1);

        logic [WIDTH-1:0] taps     [DEPTH];
        logic [WIDTH-1:0] taps_nxt [DEPTH];
        logic [SUMW-1:0]  fill;
        logic [SUMW-1:0]  fill_nxt;
        logic [OW-1:0]    result;
        logic [OW-1:0]    data_q;
        logic             valid_q;

        // Results are formed from the post-shift taps so out_data lands one cycle after the accept.
        always_comb begin
            taps_nxt[0] = in_data[c*WIDTH +: WIDTH];
            for (int k = 1; k < DEPTH; k++) begin
                taps_nxt[k] = taps[k-1];
            end
        end

        assign fill_nxt = (fill == FULL) ? fill : fill + 1'b1;

        case (MODE)
            1: begin : g_sum
                always_comb begin
                    // NOTE: the accumulator gets a default before the loop so no latch is inferred.
                    result = '0;
                    for (int k = 0; k < DEPTH; k++) begin
                        result = result + OW'(taps_nxt[k]);
                    end
                end
            end
            2: begin : g_xor
                logic [WIDTH-1:0] x;
                always_comb begin
                    x = '0;
                    for (int k = 0; k < DEPTH; k++) begin
                        x = x ^ taps_nxt[k];
                    end
                end
                assign result = OW'(x);
            end
            default: begin : g_delay
                assign result = OW'(taps_nxt[DEPTH-1]);
            end
        endcase

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                // NOTE: the taps are real state visible through out_data, so they are reset like any flop.
                for (int k = 0; k < DEPTH; k++) begin
                    taps[k] <= '0;
                end
                fill    <= '0;
                valid_q <= 1'b0;
                data_q  <= '0;
            end else if (clear) begin
                for (int k = 0; k < DEPTH; k++) begin
                    taps[k] <= '0;
                end
                fill    <= '0;
                valid_q <= 1'b0;
                data_q  <= '0;
            end else if (in_valid) begin
                // NOTE: non-blocking updates let every tap take its neighbour's pre-edge value.
                for (int k = 0; k < DEPTH; k++) begin
                    taps[k] <= taps_nxt[k];
                end
                fill    <= fill_nxt;
                valid_q <= (fill_nxt == FULL);
                data_q  <= result;
            end else begin
                valid_q <= 1'b0;
            end
        end

        assign out_valid[c]           = valid_q;
        assign out_data[c*OW +: OW]   = data_q;
    end

endmodule

// File: tb/tb_gen_tap_bank.sv
// Directed bench for gen_tap_bank: one instance per MODE sharing stimulus, table-driven checks.
module tb_gen_tap_bank;

    localparam int WIDTH = 8;
    localparam int NCH   = 4;
    localparam int OW    = WIDTH + $clog2(NCH + 1);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic [NCH*WIDTH-1:0] in_data;
`ifdef GEN_TAP_BANK_FLUSH_EN
    logic                 flush;
`endif
    logic [NCH-1:0]       ov0, ov1, ov2;
    logic [NCH*OW-1:0]    od0, od1, od2;

    always #5 clk = ~clk;

    gen_tap_bank #(.WIDTH(WIDTH), .NCH(NCH), .MODE(0)) dut0 (
        .clk(clk), .rst(rst),
`ifdef GEN_TAP_BANK_FLUSH_EN
        .flush(flush),
`endif
        .in_valid(in_valid), .in_data(in_data), .out_valid(ov0), .out_data(od0));

    gen_tap_bank #(.WIDTH(WIDTH), .NCH(NCH), .MODE(1)) dut1 (
        .clk(clk), .rst(rst),
`ifdef GEN_TAP_BANK_FLUSH_EN
        .flush(flush),
`endif
        .in_valid(in_valid), .in_data(in_data), .out_valid(ov1), .out_data(od1));

    gen_tap_bank #(.WIDTH(WIDTH), .NCH(NCH), .MODE(2)) dut2 (
        .clk(clk), .rst(rst),
`ifdef GEN_TAP_BANK_FLUSH_EN
        .flush(flush),
`endif
        .in_valid(in_valid), .in_data(in_data), .out_valid(ov2), .out_data(od2));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NCH*OW-1:0] pk(input int d0, input int d1, input int d2, input int d3);
        return {OW'(d3), OW'(d2), OW'(d1), OW'(d0)};
    endfunction

    function automatic logic get_v(input int dut, input int ch);
        case (dut)
            1:       return ov1[ch];
            2:       return ov2[ch];
            default: return ov0[ch];
        endcase
    endfunction

    function automatic logic [OW-1:0] get_d(input int dut, input int ch);
        case (dut)
            1:       return od1[ch*OW +: OW];
            2:       return od2[ch*OW +: OW];
            default: return od0[ch*OW +: OW];
        endcase
    endfunction

    task automatic check_all_zero(input string name);
        check({name, "_v0"}, 64'(ov0), 64'd0);
        check({name, "_d0"}, 64'(od0), 64'd0);
        check({name, "_v1"}, 64'(ov1), 64'd0);
        check({name, "_d1"}, 64'(od1), 64'd0);
        check({name, "_v2"}, 64'(ov2), 64'd0);
        check({name, "_d2"}, 64'(od2), 64'd0);
    endtask

    // Full-bank vectors: same sample on every channel, all three instances compared.
    typedef struct {
        logic                 vld;
        logic [7:0]           smp;
        logic [NCH-1:0]       exp_v;
        logic [NCH*OW-1:0]    exp_d0;
        logic [NCH*OW-1:0]    exp_d1;
        logic [NCH*OW-1:0]    exp_d2;
    } full_vec_t;

    // Spot vectors: one instance/channel compared; rst rows pulse reset mid-cycle.
    typedef struct {
        logic          rst;
        logic          vld;
        logic [7:0]    smp;
        int            dut;
        int            ch;
        logic          exp_v;
        logic [OW-1:0] exp_d;
    } spot_vec_t;

    full_vec_t fvecs[$];
    spot_vec_t svecs[$];

    function automatic void addf(input logic vld, input int smp, input logic [NCH-1:0] ev,
                                 input logic [NCH*OW-1:0] e0, input logic [NCH*OW-1:0] e1,
                                 input logic [NCH*OW-1:0] e2);
        full_vec_t f;
        f.vld = vld; f.smp = 8'(smp); f.exp_v = ev;
        f.exp_d0 = e0; f.exp_d1 = e1; f.exp_d2 = e2;
        fvecs.push_back(f);
    endfunction

    function automatic void adds(input logic vld, input int smp, input int dut, input int ch,
                                 input logic ev, input int ed);
        spot_vec_t s;
        s.rst = 1'b0; s.vld = vld; s.smp = 8'(smp); s.dut = dut; s.ch = ch;
        s.exp_v = ev; s.exp_d = OW'(ed);
        svecs.push_back(s);
    endfunction

    function automatic void add_rst();
        spot_vec_t s;
        s.rst = 1'b1; s.vld = 1'b0; s.smp = '0; s.dut = 0; s.ch = 0;
        s.exp_v = 1'b0; s.exp_d = '0;
        svecs.push_back(s);
    endfunction

    initial begin
        // Samples 1..5 on all channels, then one idle cycle (outputs hold, valid drops).
        addf(1, 1, 4'b0001, pk(1,0,0,0), pk(1,1,1,1),  pk(1,1,1,1));
        addf(1, 2, 4'b0011, pk(2,1,0,0), pk(2,3,3,3),  pk(2,3,3,3));
        addf(1, 3, 4'b0111, pk(3,2,1,0), pk(3,5,6,6),  pk(3,1,0,0));
        addf(1, 4, 4'b1111, pk(4,3,2,1), pk(4,7,9,10), pk(4,7,5,4));
        addf(1, 5, 4'b1111, pk(5,4,3,2), pk(5,9,12,14), pk(5,1,2,0));
        addf(0, 0, 4'b0000, pk(5,4,3,2), pk(5,9,12,14), pk(5,1,2,0));

        // MODE 1 window sum on ch3, then saturation with 255s.
        add_rst();
        adds(1, 10, 1, 3, 0, 10);
        adds(1, 20, 1, 3, 0, 30);
        adds(1, 30, 1, 3, 0, 60);
        adds(1, 40, 1, 3, 1, 100);
        adds(1, 50, 1, 3, 1, 140);
        adds(1, 255, 1, 3, 1, 375);
        adds(1, 255, 1, 3, 1, 600);
        adds(1, 255, 1, 3, 1, 815);
        adds(1, 255, 1, 3, 1, 1020);
        // MODE 2 window XOR on ch1.
        add_rst();
        adds(1, 'hF0, 2, 1, 0, 'hF0);
        adds(1, 'h0F, 2, 1, 1, 'hFF);
        adds(1, 'hFF, 2, 1, 1, 'hF0);
        // MODE 0 ch2 with a stall in the middle of the fill.
        add_rst();
        adds(1, 7, 0, 2, 0, 0);
        adds(1, 8, 0, 2, 0, 0);
        adds(0, 0, 0, 2, 0, 0);
        adds(0, 0, 0, 2, 0, 0);
        adds(0, 0, 0, 2, 0, 0);
        adds(1, 9, 0, 2, 1, 7);
        adds(0, 0, 0, 2, 0, 7);
        // Reset after two accepts: ch3 needs four fresh accepts.
        add_rst();
        adds(1, 1, 0, 3, 0, 0);
        adds(1, 2, 0, 3, 0, 0);
        add_rst();
        adds(1, 3, 0, 3, 0, 0);
        adds(1, 4, 0, 3, 0, 0);
        adds(1, 5, 0, 3, 0, 0);
        adds(1, 6, 0, 3, 1, 3);
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
`ifdef GEN_TAP_BANK_FLUSH_EN
        flush    = 1'b0;
`endif
        #1;
        repeat (2) @(negedge clk);
        check_all_zero("in_reset");
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("idle%0d_v", i), 64'({ov0, ov1, ov2}), 64'd0);
            check($sformatf("idle%0d_d", i), 64'({od0, od1, od2}), 64'd0);
        end

        foreach (fvecs[i]) begin
            in_valid = fvecs[i].vld;
            in_data  = {NCH{fvecs[i].smp}};
            @(negedge clk);
            check($sformatf("full%0d_v0", i), 64'(ov0), 64'(fvecs[i].exp_v));
            check($sformatf("full%0d_v1", i), 64'(ov1), 64'(fvecs[i].exp_v));
            check($sformatf("full%0d_v2", i), 64'(ov2), 64'(fvecs[i].exp_v));
            check($sformatf("full%0d_d0", i), 64'(od0), 64'(fvecs[i].exp_d0));
            check($sformatf("full%0d_d1", i), 64'(od1), 64'(fvecs[i].exp_d1));
            check($sformatf("full%0d_d2", i), 64'(od2), 64'(fvecs[i].exp_d2));
        end

        foreach (svecs[i]) begin
            if (svecs[i].rst) begin
                in_valid = 1'b0;
                rst = 1'b1;
                #2;
                check_all_zero($sformatf("rst%0d", i));
                #1;
                rst = 1'b0;
                @(negedge clk);
            end else begin
                in_valid = svecs[i].vld;
                in_data  = {NCH{svecs[i].smp}};
                @(negedge clk);
                check($sformatf("spot%0d_m%0d_ch%0d_v", i, svecs[i].dut, svecs[i].ch),
                      64'(get_v(svecs[i].dut, svecs[i].ch)), 64'(svecs[i].exp_v));
                check($sformatf("spot%0d_m%0d_ch%0d_d", i, svecs[i].dut, svecs[i].ch),
                      64'(get_d(svecs[i].dut, svecs[i].ch)), 64'(svecs[i].exp_d));
            end
        end
        in_valid = 1'b0;
        @(negedge clk);

`ifdef GEN_TAP_BANK_FLUSH_EN
        in_valid = 1'b1; in_data = {NCH{8'd1}};
        @(negedge clk);
        in_data = {NCH{8'd2}};
        @(negedge clk);
        flush = 1'b1; in_data = {NCH{8'd99}};
        @(negedge clk);
        flush = 1'b0;
        check_all_zero("flush");
        in_data = {NCH{8'd3}};
        @(negedge clk);
        check("flush_a3_v0", 64'(ov0), 64'b0001);
        check("flush_a3_ch0", 64'(get_d(0, 0)), 64'd3);
        check("flush_a3_ch1", 64'(get_d(0, 1)), 64'd0);
        in_data = {NCH{8'd4}};
        @(negedge clk);
        check("flush_a4_v0", 64'(ov0), 64'b0011);
        check("flush_a4_ch1", 64'(get_d(0, 1)), 64'd3);
        check("flush_a4_sum1", 64'(get_d(1, 1)), 64'd7);
        in_valid = 1'b0;
        @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
